// File: rtl/dm_stream_if.sv
// Bus bundle for dm_stream: processor port A and the display-side burst stream.
//   master: the requester (CPU for port A, display/VGA engine for the stream side)
//   slave : the dm_stream memory itself
// Port A signals: addr, re, we, wrt_data -> rd_data
// Stream signals: strm_start, strm_addr, strm_len, strm_rdy
//                 -> strm_data, strm_vld, strm_busy, strm_done
interface dm_stream_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned LEN_W  = 14
) ();

  // Port A
  logic [ADDR_W-1:0] addr;
  logic              re;
  logic              we;
  logic [DATA_W-1:0] wrt_data;
  logic [DATA_W-1:0] rd_data;

  // Burst stream
  logic              strm_start;
  logic [ADDR_W-1:0] strm_addr;
  logic [LEN_W-1:0]  strm_len;
  logic [DATA_W-1:0] strm_data;
  logic              strm_vld;
  logic              strm_rdy;
  logic              strm_busy;
  logic              strm_done;

  modport master (
    output addr, re, we, wrt_data, strm_start, strm_addr, strm_len, strm_rdy,
    input  rd_data, strm_data, strm_vld, strm_busy, strm_done
  );

  modport slave (
    input  addr, re, we, wrt_data, strm_start, strm_addr, strm_len, strm_rdy,
    output rd_data, strm_data, strm_vld, strm_busy, strm_done
  );

endinterface

// File: rtl/dm_stream.sv
// dm_stream: data memory for the BMP display datapath.
// Port A (negedge clk) is the processor's single-ported read/write port with a
// registered rd_data. Port B (posedge clk) is a burst-read stream engine: a
// start address and word count are latched on strm_start, then words are pushed
// through a 2-entry output buffer with a valid/ready handshake.
// Ports:
//   clk   - single clock for both ports
//   rst_n - synchronous active-low reset
//   bus   - dm_stream_if slave modport (port A and stream signals)
module dm_stream #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned LEN_W  = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  dm_stream_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Port A: negedge timing, contents are never reset
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(negedge clk) begin
    if (bus.we && !bus.re) begin
      mem[bus.addr] <= bus.wrt_data;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (bus.re && !bus.we) begin
      rd_data_q <= mem[bus.addr];
    end
  end

  assign bus.rd_data = rd_data_q;

  // ---------------------------------------------------------------------------
  // Port B: burst stream engine
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              done_q, done_d;
  logic              inflight_q;
  logic [DATA_W-1:0] rd_word_q;
  logic [DATA_W-1:0] buf_q [2];
  logic              wr_idx_q, rd_idx_q;
  logic [1:0]        count_q, count_d;

  logic              issue;
  logic              push;
  logic              pop;
  logic [2:0]        occ_after;
  logic              room;

  assign pop  = (count_q != 2'd0) && bus.strm_rdy;
  // The word read on the previous edge always lands in the buffer this edge.
  assign push = inflight_q;

  // Buffer occupancy after this edge; a new read may only issue if its word will
  // still fit when it returns, so occupancy plus in-flight never exceeds 2.
  assign occ_after = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign room      = (occ_after <= 3'd1);

  assign count_d = count_q + 2'(push) - 2'(pop);

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    issue    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.strm_start) begin
          rd_ptr_d = bus.strm_addr;
          remain_d = bus.strm_len;
          if (bus.strm_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (remain_q != '0) begin
          if (room) begin
            issue    = 1'b1;
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);  // wraps DEPTH-1 -> 0
            remain_d = remain_q - LEN_W'(1);
          end
        end else begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Finished once nothing is in flight and the last buffered word leaves.
        if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rd_ptr_q   <= '0;
      remain_q   <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      rd_word_q  <= '0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wr_idx_q   <= 1'b0;
      rd_idx_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      remain_q   <= remain_d;
      done_q     <= done_d;
      inflight_q <= issue;
      count_q    <= count_d;
      if (issue) begin
        rd_word_q <= mem[rd_ptr_q];
      end
      if (push) begin
        buf_q[wr_idx_q] <= rd_word_q;
        wr_idx_q        <= ~wr_idx_q;
      end
      if (pop) begin
        rd_idx_q <= ~rd_idx_q;
      end
    end
  end

  // Head of the buffer; with count==2 no push can occur, so the head is stable
  // while the consumer stalls.
  assign bus.strm_data = buf_q[rd_idx_q];
  assign bus.strm_vld  = (count_q != 2'd0);
  assign bus.strm_busy = (state_q != StIdle);
  assign bus.strm_done = done_q;

endmodule

// File: doc/dm_stream.md
Name: dm_stream

Overview:
- Parametrised data memory for the BMP display datapath.
- Port A is the processor port: single-ported read/write, negedge timing, drop-in for the current 8Kx16 data memory.
- Port B is a posedge burst-read stream engine. The display/VGA side programs a start address and length, then pulls words through a valid/ready handshake with backpressure, without stalling the CPU.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 13, address width; DEPTH = 2**ADDR_W words.
- LEN_W, 14, burst length width; allows a full-memory burst of DEPTH words.

Ports:
- clk  input  1  single clock for both ports.
- rst_n  input  1  synchronous active-low reset.
- addr  input  ADDR_W  port A word address.
- re  input  1  port A read enable.
- we  input  1  port A write enable.
- wrt_data  input  DATA_W  port A write data.
- rd_data  output  DATA_W  port A read data, registered.
- strm_start  input  1  one-cycle burst request.
- strm_addr  input  ADDR_W  burst start address, sampled with strm_start.
- strm_len  input  LEN_W  burst word count, sampled with strm_start.
- strm_data  output  DATA_W  stream word.
- strm_vld  output  1  strm_data valid.
- strm_rdy  input  1  consumer accepts the word when strm_vld&&strm_rdy at posedge.
- strm_busy  output  1  burst in progress.
- strm_done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:

Port A (negedge clk):
- re&&~we: rd_data <= mem[addr].
- we&&~re: mem[addr] <= wrt_data.
- re&&we, or neither: no access; rd_data holds.
- Any cycle with rst_n low at negedge: rd_data <= 0.
- Memory contents are not reset.

Port B (posedge clk):
- Reset: strm_vld=0, strm_busy=0, strm_done=0, strm_data=0.
- FSM states:
  - IDLE: on strm_start, latch rd_ptr=strm_addr and remain=strm_len.
    - strm_len==0: assert strm_done next cycle, stay IDLE, emit no data.
    - Otherwise go to RUN; strm_busy=1 from the next cycle.
  - RUN:
    - Issue a read of mem[rd_ptr] whenever the 2-entry output buffer has room for the returning word. Occupancy plus in-flight reads must be ≤2.
    - Read latency is 1 posedge; the word enters the buffer.
    - Each issue: rd_ptr <= rd_ptr+1, wrapping DEPTH-1 -> 0; remain <= remain-1.
    - At remain==0 with no issue pending, go to DRAIN.
  - DRAIN: the buffer empties via handshakes. When the last word is accepted, strm_done=1 for exactly one cycle; strm_busy falls the same cycle; return to IDLE.
- Output handshake:
  - strm_data/strm_vld come from the buffer head.
  - While strm_vld=1 and strm_rdy=0, strm_data and strm_vld are held stable.
  - With strm_rdy held high, throughput is 1 word/cycle after a first-word latency of 2 cycles from strm_start.
- Ordering: words are delivered strictly in address order; none dropped or duplicated under any strm_rdy pattern.
- strm_start while strm_busy=1 is ignored.
- Coherency:
  - A port A write at negedge of cycle N is visible to a port B read issued at posedge N+1.
  - Words already read into the buffer are not updated.
- Reset mid-burst: FSM to IDLE, buffer flushed, strm_vld=0, no strm_done pulse.

Test Plan:
1. Port A: write 0xBEEF @0x0005 and 0x1234 @0x1FFF; read back -> rd_data=0xBEEF then 0x1234 at the following negedges. re&&we -> rd_data holds and mem is unchanged.
2. Burst, strm_rdy=1: preload mem[0x100..0x107]=i; start addr=0x100, len=8 -> 8 consecutive words 0..7, first strm_vld 2 cycles after start, strm_done 1 cycle after the last accept, strm_busy low afterwards.
3. Backpressure: same burst with strm_rdy toggling randomly 50% -> exactly 8 accepts, in order 0..7, strm_data stable whenever vld&&~rdy.
4. Wrap and zero length: start addr=0x1FFE, len=4 -> words from 0x1FFE, 0x1FFF, 0x0000, 0x0001. Start with len=0 -> strm_done next cycle, strm_vld never asserted.
5. Concurrency: a burst of 16 while port A writes 0xAAAA to a not-yet-fetched address in the burst range -> stream returns 0xAAAA at that position. Port A reads return correct data throughout. strm_start mid-burst ignored.
6. Reset mid-burst: rst_n low for 1 cycle after 3 accepts -> strm_vld/busy=0, no done, rd_data=0. A new burst then runs correctly from its new start address.
